vga_zapper_sense: RTL and testbench

Light-gun (zapper) sensor model that reads the finished VGA stream at the end of the draw pipeline (after `draw_duck`). On a trigger pulse it latches the aim point, waits for the next frame boundary, then counts bright, non-blanked pixels in a square window around the aim point for one full frame and reports hit/miss. It consumes the same `itf_vga` stream the drawing modules produce, as an observer only, and feeds the game logic's hit decision.

---
 rtl/vga_zapper_sense_pkg.sv | 33 +++
 rtl/vga_zapper_sense_if.sv | 19 +
 rtl/vga_zapper_sense_window_check.sv | 73 +++++++
 rtl/vga_zapper_sense.sv | 149 ++++++++++++++
 tb/tb_vga_zapper_sense.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_zapper_sense_pkg.sv
// Shared types, screen limits and small helpers for the zapper light-gun
// sensor.
//   zs_state_t  : sensor FSM states
//   HOR_PIXELS  : visible screen width
//   VER_PIXELS  : visible screen height
//   win_lo/hi   : clipped window bounds, computed 12 bits wide so nothing wraps
//   sat_inc     : 8-bit increment that sticks at 255
`timescale 1ns/1ps
package vga_zapper_sense_pkg;

    typedef enum logic [1:0] {ZS_IDLE, ZS_WAIT, ZS_SCAN, ZS_DONE} zs_state_t;

    localparam int HOR_PIXELS = 1024;
    localparam int VER_PIXELS = 768;

    function automatic logic [11:0] win_lo(input logic [10:0] c, input logic [11:0] half);
        logic [11:0] c12;
        c12 = {1'b0, c};
        return (c12 < half) ? 12'd0 : c12 - half;
    endfunction

    function automatic logic [11:0] win_hi(input logic [10:0] c, input logic [11:0] half,
                                           input logic [11:0] limit);
        logic [11:0] sum;
        sum = {1'b0, c} + half;
        return (sum > limit) ? limit : sum;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic en);
        return (en && (v != 8'hFF)) ? v + 8'd1 : v;
    endfunction

endpackage

// File: rtl/vga_zapper_sense_if.sv
// VGA pixel stream as produced by each drawing stage.
//   hcount/vcount : pixel coordinates
//   hblnk/vblnk   : blanking flags
//   hsync/vsync   : sync pulses
//   rgb           : 4:4:4 pixel colour
// master drives the stream, slave observes it.
`timescale 1ns/1ps
interface itf_vga;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hblnk;
    logic        vblnk;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;

    modport master (output hcount, vcount, hblnk, vblnk, hsync, vsync, rgb);
    modport slave  (input  hcount, vcount, hblnk, vblnk, hsync, vsync, rgb);
endinterface

// File: rtl/vga_zapper_sense_window_check.sv
// Pixel qualification stage of the zapper sensor.
// Registers the incoming stream and new_frame once, then flags the registered
// pixel when it is visible, inside the latched window and bright on all three
// colour channels.
//   clk, rst        : pixel clock, asynchronous active-high reset
//   vga             : observed stream (slave)
//   new_frame       : frame boundary pulse, delayed here by the same one cycle
//   x_lo..y_hi      : inclusive window bounds (12 bit)
//   frame_start     : new_frame aligned with the registered pixel
//   px_qual         : registered pixel counts as a bright window hit
// The sync pulses are not needed to qualify a pixel and are left unread.
`timescale 1ns/1ps
module zapper_window_check
    import vga_zapper_sense_pkg::*;
#(
    parameter logic [3:0] BRIGHT_MIN = 4'hC
) (
    input  logic        clk,
    input  logic        rst,
    itf_vga.slave       vga,
    input  logic        new_frame,
    input  logic [11:0] x_lo,
    input  logic [11:0] x_hi,
    input  logic [11:0] y_lo,
    input  logic [11:0] y_hi,
    output logic        frame_start,
    output logic        px_qual
);

    logic [10:0] hcount_reg;
    logic [10:0] vcount_reg;
    logic        hblnk_reg;
    logic        vblnk_reg;
    logic [11:0] rgb_reg;
    logic        nf_reg;
    logic [2:0]  chan_ok;
    logic        in_x;
    logic        in_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_reg <= '0;
            vcount_reg <= '0;
            hblnk_reg  <= 1'b1;
            vblnk_reg  <= 1'b1;
            rgb_reg    <= '0;
            nf_reg     <= 1'b0;
        end else begin
            hcount_reg <= vga.hcount;
            vcount_reg <= vga.vcount;
            hblnk_reg  <= vga.hblnk;
            vblnk_reg  <= vga.vblnk;
            rgb_reg    <= vga.rgb;
            nf_reg     <= new_frame;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            assign chan_ok[gi] = (rgb_reg[4*gi +: 4] >= BRIGHT_MIN);
        end
    endgenerate

    always_comb begin
        in_x    = ({1'b0, hcount_reg} >= x_lo) && ({1'b0, hcount_reg} <= x_hi);
        in_y    = ({1'b0, vcount_reg} >= y_lo) && ({1'b0, vcount_reg} <= y_hi);
        px_qual = !hblnk_reg && !vblnk_reg && in_x && in_y && (&chan_ok);
    end

    assign frame_start = nf_reg;

endmodule

// File: rtl/vga_zapper_sense.sv
// Light-gun (zapper) sensor observing the finished VGA stream.
// A trigger latches the aim window; the sensor then waits for the next frame
// boundary, counts bright visible pixels inside the window for exactly one
// frame and reports hit/miss.
//   clk, rst      : pixel clock, asynchronous active-high reset
//   in            : observed stream (slave)
//   new_frame     : one-cycle pulse at the first pixel of each frame
//   trigger       : one-cycle shot request
//   aim_x, aim_y  : crosshair position
//   busy          : shot in progress
//   result_valid  : one-cycle pulse, hit/bright_count final in that cycle
//   hit           : count >= THRESHOLD, held until the next result
//   bright_count  : saturating count of the last scan, held
`timescale 1ns/1ps
module vga_zapper_sense
    import vga_zapper_sense_pkg::*;
#(
    parameter int         WIN        = 4,
    parameter int         THRESHOLD  = 16,
    parameter logic [3:0] BRIGHT_MIN = 4'hC
) (
    input  logic        clk,
    input  logic        rst,
    itf_vga.slave       in,
    input  logic        new_frame,
    input  logic        trigger,
    input  logic [10:0] aim_x,
    input  logic [10:0] aim_y,
    output logic        busy,
    output logic        result_valid,
    output logic        hit,
    output logic [7:0]  bright_count
);

    localparam logic [11:0] HALF    = 12'(WIN);
    localparam logic [11:0] X_LIMIT = 12'(HOR_PIXELS - 1);
    localparam logic [11:0] Y_LIMIT = 12'(VER_PIXELS - 1);
    localparam logic [8:0]  THR     = 9'(THRESHOLD);

    zs_state_t   state_reg, state_next;
    logic [7:0]  count_reg, count_next;
    logic [11:0] x_lo_reg, x_lo_next;
    logic [11:0] x_hi_reg, x_hi_next;
    logic [11:0] y_lo_reg, y_lo_next;
    logic [11:0] y_hi_reg, y_hi_next;
    logic        armed_reg, armed_next;
    logic        hit_reg, hit_next;
    logic [7:0]  bc_reg, bc_next;
    logic        frame_start;
    logic        px_qual;

    zapper_window_check #(
        .BRIGHT_MIN (BRIGHT_MIN)
    ) u_check (
        .clk         (clk),
        .rst         (rst),
        .vga         (in),
        .new_frame   (new_frame),
        .x_lo        (x_lo_reg),
        .x_hi        (x_hi_reg),
        .y_lo        (y_lo_reg),
        .y_hi        (y_hi_reg),
        .frame_start (frame_start),
        .px_qual     (px_qual)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ZS_IDLE;
            count_reg <= '0;
            x_lo_reg  <= '0;
            x_hi_reg  <= '0;
            y_lo_reg  <= '0;
            y_hi_reg  <= '0;
            armed_reg <= 1'b0;
            hit_reg   <= 1'b0;
            bc_reg    <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            x_lo_reg  <= x_lo_next;
            x_hi_reg  <= x_hi_next;
            y_lo_reg  <= y_lo_next;
            y_hi_reg  <= y_hi_next;
            armed_reg <= armed_next;
            hit_reg   <= hit_next;
            bc_reg    <= bc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        x_lo_next  = x_lo_reg;
        x_hi_next  = x_hi_reg;
        y_lo_next  = y_lo_reg;
        y_hi_next  = y_hi_reg;
        armed_next = armed_reg;
        hit_next   = hit_reg;
        bc_next    = bc_reg;
        case (state_reg)
            ZS_IDLE: begin
                if (trigger) begin
                    state_next = ZS_WAIT;
                    count_next = '0;
                    x_lo_next  = win_lo(aim_x, HALF);
                    x_hi_next  = win_hi(aim_x, HALF, X_LIMIT);
                    y_lo_next  = win_lo(aim_y, HALF);
                    y_hi_next  = win_hi(aim_y, HALF, Y_LIMIT);
                    armed_next = 1'b0;
                end
            end
            ZS_WAIT: begin
                // The first WAIT cycle sees the delayed copy of a new_frame
                // that coincided with the trigger; that one must not start
                // the scan, hence the one-cycle arming delay.
                armed_next = 1'b1;
                if (frame_start && armed_reg) begin
                    state_next = ZS_SCAN;
                    // The boundary pixel is the first pixel of the scanned
                    // frame, so it is counted here rather than lost.
                    count_next = sat_inc(count_reg, px_qual);
                end
            end
            ZS_SCAN: begin
                if (frame_start) begin
                    // This pixel already belongs to the following frame.
                    state_next = ZS_DONE;
                    hit_next   = ({1'b0, count_reg} >= THR);
                    bc_next    = count_reg;
                end else begin
                    count_next = sat_inc(count_reg, px_qual);
                end
            end
            ZS_DONE: begin
                state_next = ZS_IDLE;
            end
            default: begin
                state_next = ZS_IDLE;
            end
        endcase
    end

    assign busy         = (state_reg != ZS_IDLE);
    assign result_valid = (state_reg == ZS_DONE);
    assign hit          = hit_reg;
    assign bright_count = bc_reg;

endmodule

// File: tb/tb_vga_zapper_sense.sv
`timescale 1ns/1ps
module tb_vga_zapper_sense;

    localparam int W     = 24;
    localparam int H     = 24;
    localparam int HT    = 30;
    localparam int VT    = 28;
    localparam int FRAME = HT * VT;
    localparam int HIST  = 131072;

    logic clk = 1'b0;
    logic rst;
    always #7.5 clk = ~clk;

    itf_vga vga ();
    logic        new_frame;
    logic [1:0]  trigger_s;
    logic [10:0] aim_x_s [2];
    logic [10:0] aim_y_s [2];
    logic [1:0]  busy_s;
    logic [1:0]  rv_s;
    logic [1:0]  hit_s;
    logic [7:0]  bc_s [2];

    vga_zapper_sense #(.WIN(4), .THRESHOLD(16), .BRIGHT_MIN(4'hC)) dut0 (
        .clk(clk), .rst(rst), .in(vga), .new_frame(new_frame),
        .trigger(trigger_s[0]), .aim_x(aim_x_s[0]), .aim_y(aim_y_s[0]),
        .busy(busy_s[0]), .result_valid(rv_s[0]), .hit(hit_s[0]), .bright_count(bc_s[0]));

    vga_zapper_sense #(.WIN(10), .THRESHOLD(16), .BRIGHT_MIN(4'hC)) dut1 (
        .clk(clk), .rst(rst), .in(vga), .new_frame(new_frame),
        .trigger(trigger_s[1]), .aim_x(aim_x_s[1]), .aim_y(aim_y_s[1]),
        .busy(busy_s[1]), .result_valid(rv_s[1]), .hit(hit_s[1]), .bright_count(bc_s[1]));

    int win_of [2] = '{4, 10};

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ox = 0, oy = 0, ox_cfg = 0, oy_cfg = 0;
    int          mode = 0, param = 0;
    logic [11:0] rnd_scene [H][W];
    bit          trig_req [2];
    int          trig_cyc [2];
    int          aim_req_x [2];
    int          aim_req_y [2];
    int          rv_cnt [2];
    int          rv_cyc [2];
    int          rv_hit [2];
    int          rv_bc [2];
    bit          busy_hist [2][HIST];

    // Scene content at a visible screen position.
    function automatic logic [11:0] scene_px(int x, int y, int row, int col);
        logic [11:0] p;
        p = 12'h000;
        case (mode)
            0: p = 12'hFFF;
            1: begin
                if (x >= 400 && x <= 411 && y >= 300 && y <= 311) p = 12'hFEC;
                else if (((x + y) % 8) == 0) p = 12'hCCC;
                else if ((x % 3) == 0) p = 12'hBFF;
                else if ((x % 3) == 1) p = 12'hFBF;
                else p = 12'hFFB;
            end
            2: p = rnd_scene[row][col];
            default: begin
                if (x >= 6 && x <= 14 && y >= 6 && y <= 14 && ((y - 6) * 9 + (x - 6)) < param)
                    p = 12'hFFF;
            end
        endcase
        return p;
    endfunction

    function automatic bit is_bright(logic [11:0] p);
        return (p[11:8] >= 4'hC) && (p[7:4] >= 4'hC) && (p[3:0] >= 4'hC);
    endfunction

    // Reference: bright visible pixels of one whole frame inside the clipped
    // square around the aim point, saturated at 255.
    function automatic int model_count(int win, int ox_i, int oy_i, int ax, int ay);
        int n;
        int x;
        int y;
        n = 0;
        for (int row = 0; row < H; row++) begin
            for (int col = 0; col < W; col++) begin
                x = ox_i + col;
                y = oy_i + row;
                if (x >= ax - win && x <= ax + win && y >= ay - win && y <= ay + win &&
                    x < 1024 && y < 768 && is_bright(scene_px(x, y, row, col)))
                    n++;
            end
        end
        return (n > 255) ? 255 : n;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Stream generator and output monitor, all on the falling edge.
    initial begin
        int pos;
        int col;
        int row;
        new_frame   = 1'b0;
        vga.hcount  = '0;
        vga.vcount  = '0;
        vga.hblnk   = 1'b1;
        vga.vblnk   = 1'b1;
        vga.hsync   = 1'b0;
        vga.vsync   = 1'b0;
        vga.rgb     = '0;
        trigger_s   = '0;
        for (int d = 0; d < 2; d++) begin
            aim_x_s[d] = '0;
            aim_y_s[d] = '0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                busy_hist[d][cyc % HIST] = busy_s[d];
                if (rv_s[d]) begin
                    rv_cnt[d]++;
                    rv_cyc[d] = cyc;
                    rv_hit[d] = int'(hit_s[d]);
                    rv_bc[d]  = int'(bc_s[d]);
                end
            end
            pos = cyc % FRAME;
            col = pos % HT;
            row = pos / HT;
            if (pos == 0) begin
                ox = ox_cfg;
                oy = oy_cfg;
            end
            new_frame  = (pos == 0);
            vga.hcount = 11'(ox + col);
            vga.vcount = 11'(oy + row);
            vga.hblnk  = (col >= W);
            vga.vblnk  = (row >= H);
            vga.hsync  = (col >= W + 1) && (col < W + 4);
            vga.vsync  = (row >= H + 1) && (row < H + 3);
            vga.rgb    = (col < W && row < H) ? scene_px(ox + col, oy + row, row, col) : 12'hFFF;
            for (int d = 0; d < 2; d++) begin
                trigger_s[d] = trig_req[d];
                if (trig_req[d]) begin
                    trig_cyc[d] = cyc;
                    trig_req[d] = 1'b0;
                    aim_x_s[d]  = 11'(aim_req_x[d]);
                    aim_y_s[d]  = 11'(aim_req_y[d]);
                end else begin
                    aim_x_s[d] = 11'($urandom_range(0, 1023));
                    aim_y_s[d] = 11'($urandom_range(0, 767));
                end
            end
        end
    end

    task automatic wait_idle(input int d);
        int k;
        k = 0;
        while (busy_hist[d][cyc % HIST] && k < 4 * FRAME) begin
            @(posedge clk);
            k++;
        end
        if (k >= 4 * FRAME) check("idle_timeout", 1, 0);
    endtask

    // One shot. sec: 0 none, >0 second trigger sec cycles after the first,
    // <0 second trigger in the result cycle.
    task automatic shot(input int d, input int ox_i, input int oy_i, input int mode_i,
                        input int param_i, input int ax, input int ay, input int phase,
                        input int sec, input int exp_hit, input int exp_bc, input string tag);
        int t;
        int f;
        int exp_cyc;
        int n0;
        int target;
        @(posedge clk);
        wait_idle(d);
        mode      = mode_i;
        param     = param_i;
        ox_cfg    = ox_i;
        oy_cfg    = oy_i;
        aim_req_x[d] = ax;
        aim_req_y[d] = ay;
        while (((cyc + 1) % FRAME) != phase) @(posedge clk);
        n0 = rv_cnt[d];
        trig_req[d] = 1'b1;
        @(posedge clk);
        t       = trig_cyc[d];
        f       = (t / FRAME + 1) * FRAME;
        exp_cyc = f + FRAME + 2;
        if (sec != 0) begin
            target = (sec > 0) ? t + sec : exp_cyc;
            while (cyc + 1 < target) @(posedge clk);
            aim_req_x[d] = (ax + 200) % 1024;
            aim_req_y[d] = (ay + 100) % 768;
            trig_req[d]  = 1'b1;
        end
        while (cyc < exp_cyc + 2) @(posedge clk);
        check({tag, "_rv_count"}, rv_cnt[d] - n0, 1);
        check({tag, "_latency"}, rv_cyc[d] - t, exp_cyc - t);
        check({tag, "_hit"}, rv_hit[d], exp_hit);
        check({tag, "_bright_count"}, rv_bc[d], exp_bc);
        check({tag, "_busy_rise"}, int'(busy_hist[d][(t + 1) % HIST]), 1);
        check({tag, "_busy_fall"}, int'(busy_hist[d][(exp_cyc + 1) % HIST]), 0);
        $display("shot %s dut%0d aim=(%0d,%0d) bright_count=%0d hit=%0d latency=%0d",
                 tag, d, ax, ay, rv_bc[d], rv_hit[d], rv_cyc[d] - t);
    endtask

    typedef struct {
        int d;
        int ox;
        int oy;
        int mode;
        int param;
        int ax;
        int ay;
        int phase;
        int exp_hit;
        int exp_bc;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int t;
        int f;
        int n0;
        int n1;
        int t2;
        int d;
        int rox;
        int roy;
        int rax;
        int ray;
        int ebc;
        vecs[0] = '{0,    0,   0, 0,  0,    0,   0, 400, 1,  25};
        vecs[1] = '{0, 1000, 744, 0,  0, 1023, 767,   0, 1,  25};
        vecs[2] = '{0,  392, 292, 1,  0,  404, 304, 420, 1,  81};
        vecs[3] = '{0,   88, 688, 1,  0,  100, 700, 100, 0,  11};
        vecs[4] = '{1,  392, 292, 0,  0,  404, 304, 839, 1, 255};
        vecs[5] = '{1,    0,   0, 0,  0,    3,   2,   5, 1, 182};
        vecs[6] = '{0,    0,   0, 3, 15,   10,  10, 200, 0,  15};
        vecs[7] = '{0,    0,   0, 3, 16,   10,  10, 300, 1,  16};
        vecs[8] = '{0,    0,   0, 0,  0,   24,  24,  50, 1,  16};

        rst = 1'b1;
        repeat (4) @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset_busy", int'(busy_s[i]), 0);
            check("reset_result_valid", int'(rv_s[i]), 0);
            check("reset_hit", int'(hit_s[i]), 0);
            check("reset_bright_count", int'(bc_s[i]), 0);
        end

        for (int i = 0; i < 9; i++)
            shot(vecs[i].d, vecs[i].ox, vecs[i].oy, vecs[i].mode, vecs[i].param,
                 vecs[i].ax, vecs[i].ay, vecs[i].phase, 0, vecs[i].exp_hit,
                 vecs[i].exp_bc, $sformatf("vec%0d", i));

        for (int i = 0; i < 10; i++) begin
            d   = i % 2;
            rox = int'($urandom_range(0, 1000));
            roy = int'($urandom_range(0, 744));
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    rnd_scene[r][c] = (d == 0)
                        ? {4'($urandom_range(10, 15)), 4'($urandom_range(10, 15)), 4'($urandom_range(10, 15))}
                        : {4'($urandom_range(8, 15)), 4'($urandom_range(8, 15)), 4'($urandom_range(8, 15))};
            rax = rox + int'($urandom_range(0, W + 8)) - 4;
            ray = roy + int'($urandom_range(0, H + 8)) - 4;
            if (rax < 0) rax = 0;
            if (rax > 1023) rax = 1023;
            if (ray < 0) ray = 0;
            if (ray > 767) ray = 767;
            mode = 2;
            ebc  = model_count(win_of[d], rox, roy, rax, ray);
            shot(d, rox, roy, 2, 0, rax, ray, int'($urandom_range(0, FRAME - 1)), 0,
                 (ebc >= 16) ? 1 : 0, ebc, $sformatf("rand%0d", i));
        end

        shot(0, 392, 292, 1, 0, 404, 304, 150, 300, 1, 81, "retrigger_busy");
        shot(0, 88, 688, 1, 0, 100, 700, 600, -1, 0, 11, "trigger_in_done");
        shot(0, 392, 292, 1, 0, 404, 304, 10, 0, 1, 81, "pre_abort");

        // Reset in the middle of a scan.
        @(posedge clk);
        wait_idle(0);
        mode = 1;
        ox_cfg = 392;
        oy_cfg = 292;
        aim_req_x[0] = 404;
        aim_req_y[0] = 304;
        trig_req[0] = 1'b1;
        @(posedge clk);
        t = trig_cyc[0];
        f = (t / FRAME + 1) * FRAME;
        while (cyc < f + 200) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_busy", int'(busy_s[0]), 0);
        check("abort_result_valid", int'(rv_s[0]), 0);
        check("abort_hit", int'(hit_s[0]), 0);
        check("abort_bright_count", int'(bc_s[0]), 0);
        check("abort_bright_count_dut1", int'(bc_s[1]), 0);
        n0 = rv_cnt[0];
        n1 = rv_cnt[1];
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        t2 = cyc;
        while (cyc < t2 + 2 * FRAME + 4) @(posedge clk);
        check("abort_no_result", (rv_cnt[0] - n0) + (rv_cnt[1] - n1), 0);
        check("abort_idle", int'(busy_hist[0][cyc % HIST]), 0);
        $display("abort sequence dut0 results_after_reset=%0d", rv_cnt[0] - n0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
